// File: rtl/multi_debouncer_pkg.sv
// rtl/multi_debouncer_pkg.sv - shared FSM state encoding and counter sizing for multi_debouncer
package multi_debouncer_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_e;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/multi_debouncer_debounce_channel.sv
// rtl/multi_debouncer_debounce_channel.sv - one line: synchroniser, counter FSM and registered strobes
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic debounced_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o,
  output logic change_d_o
);

  localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  state_e                 state_q;
  logic                   db_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   glitch_q;
  logic                   s;
  logic                   accept_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Accepting from STABLE only happens in the single-sample configuration.
  always_comb begin
    accept_d = 1'b0;
    if (s != db_q) begin
      if (state_q == STABLE)
        accept_d = (DEBOUNCE_CYCLES == 1);
      else
        accept_d = (cnt_q == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= line_i;
      db_q     <= line_i;
      cnt_q    <= '0;
      state_q  <= STABLE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync_q[0] <= line_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      rise_q   <= accept_d & s;
      fall_q   <= accept_d & ~s;
      glitch_q <= 1'b0;
      case (state_q)
        STABLE: begin
          if (s == db_q) begin
            cnt_q <= '0;
          end else if (accept_d) begin
            db_q <= s;
          end else begin
            cnt_q   <= CW'(1);
            state_q <= PENDING;
          end
        end
        PENDING: begin
          if (s == db_q) begin
            cnt_q    <= '0;
            glitch_q <= 1'b1;
            state_q  <= STABLE;
          end else if (accept_d) begin
            db_q    <= s;
            cnt_q   <= '0;
            state_q <= STABLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= STABLE;
      endcase
    end
  end

  assign debounced_o = db_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign glitch_o    = glitch_q;
  assign change_d_o  = accept_d;

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel debouncer top; MULTI_DEBOUNCER_IRQ_EN adds sticky event/IRQ register
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] line,
`ifdef MULTI_DEBOUNCER_IRQ_EN
  input  logic [CHANNELS-1:0] irq_clear,
  output logic [CHANNELS-1:0] event_pending,
  output logic                irq,
`endif
  output logic [CHANNELS-1:0] debounced_line,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] glitch,
  output logic                any_change
);

  logic [CHANNELS-1:0] change_d;
  logic                any_change_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .line_i     (line[i]),
      .debounced_o(debounced_line[i]),
      .rise_o     (rise[i]),
      .fall_o     (fall[i]),
      .glitch_o   (glitch[i]),
      .change_d_o (change_d[i])
    );
  end

  // Registered from the channels' next-state accepts so it lines up with rise/fall.
  always_ff @(posedge clk) begin
    if (!reset) any_change_q <= 1'b0;
    else        any_change_q <= |change_d;
  end

  assign any_change = any_change_q;

`ifdef MULTI_DEBOUNCER_IRQ_EN
  logic [CHANNELS-1:0] event_pending_q;
  logic [CHANNELS-1:0] event_pending_d;
  logic                irq_q;

  assign event_pending_d = (event_pending_q & ~irq_clear) | (rise | fall);

  always_ff @(posedge clk) begin
    if (!reset) begin
      event_pending_q <= '0;
      irq_q           <= 1'b0;
    end else begin
      event_pending_q <= event_pending_d;
      irq_q           <= |event_pending_d;
    end
  end

  assign event_pending = event_pending_q;
  assign irq           = irq_q;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - directed plus randomized bench against a run-length reference model
module tb_multi_debouncer;

  localparam int CH = 4;
  localparam int D  = 8;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] line;
  logic [CH-1:0] debounced_line, rise, fall, glitch;
  logic          any_change;
`ifdef MULTI_DEBOUNCER_IRQ_EN
  logic [CH-1:0] irq_clear;
  logic [CH-1:0] event_pending;
  logic          irq;
`endif

  int checks = 0;
  int errors = 0;

  logic [CH-1:0] m_db, m_rise, m_fall, m_glitch, m_ep;
  logic          m_any, m_irq;
  int            m_run [CH];
  logic [CH-1:0] m_hist [$];

  always #5 clk = ~clk;

  multi_debouncer #(.CHANNELS(CH), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk           (clk),
    .reset         (reset),
    .line          (line),
`ifdef MULTI_DEBOUNCER_IRQ_EN
    .irq_clear     (irq_clear),
    .event_pending (event_pending),
    .irq           (irq),
`endif
    .debounced_line(debounced_line),
    .rise          (rise),
    .fall          (fall),
    .glitch        (glitch),
    .any_change    (any_change)
  );

  task automatic chk(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // A level is accepted once the synchronised line has disagreed with it for D samples in a row;
  // any agreeing sample before that throws the partial run away as a glitch.
  task automatic model_edge();
    logic [CH-1:0] s;
    logic [CH-1:0] clr;
`ifdef MULTI_DEBOUNCER_IRQ_EN
    clr = irq_clear;
`else
    clr = '0;
`endif
    if (!reset) begin
      m_hist = {};
      for (int k = 0; k < S; k++) m_hist.push_back(line);
      m_db = line; m_rise = '0; m_fall = '0; m_glitch = '0; m_any = 1'b0;
      m_ep = '0; m_irq = 1'b0;
      for (int i = 0; i < CH; i++) m_run[i] = 0;
    end else begin
      m_ep  = (m_ep & ~clr) | m_rise | m_fall;
      m_irq = |m_ep;
      s = m_hist.pop_front();
      m_hist.push_back(line);
      m_rise = '0; m_fall = '0; m_glitch = '0;
      for (int i = 0; i < CH; i++) begin
        if (s[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_db[i] = s[i];
            if (s[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          if (m_run[i] > 0) m_glitch[i] = 1'b1;
          m_run[i] = 0;
        end
      end
      m_any = |(m_rise | m_fall);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("debounced_line", debounced_line, m_db);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("glitch", glitch, m_glitch);
    chk("any_change", {3'b0, any_change}, {3'b0, m_any});
    chk("exclusive", rise & fall | rise & glitch | fall & glitch, '0);
`ifdef MULTI_DEBOUNCER_IRQ_EN
    chk("event_pending", event_pending, m_ep);
    chk("irq", {3'b0, irq}, {3'b0, m_irq});
`endif
  endtask

  initial begin : stim
    int n, hit, cnt_r, cnt_f, cnt_g, cnt_any;
    reset = 1'b0;
    line  = 4'b1010;
`ifdef MULTI_DEBOUNCER_IRQ_EN
    irq_clear = '0;
`endif

    // Reset state and release without edges
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("reset_db", debounced_line, 4'b1010);
    cnt_r = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (rise != 0 || fall != 0) cnt_r++;
    end
    chk("reset_no_edges", 4'(cnt_r), 4'd0);

    // Clean rise on channel 0: 10 edges after the first sampling edge
    line[0] = 1'b1;
    hit = 0;
    for (n = 1; n <= 30; n++) begin
      tick();
      if (rise[0]) begin
        hit = n;
        chk("rise0_any", {3'b0, any_change}, 4'd1);
        break;
      end
    end
    chk("rise0_latency", 4'(hit), 4'd10);
    tick();
    chk("rise0_one_cycle", {3'b0, rise[0]}, 4'd0);

    // Short low pulse on channel 1 is rejected
    line[1] = 1'b0;
    repeat (5) tick();
    line[1] = 1'b1;
    cnt_g = 0; cnt_f = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      cnt_g += int'(glitch[1]);
      cnt_f += int'(fall[1]);
      chk("ch1_hold", {3'b0, debounced_line[1]}, 4'd1);
    end
    chk("ch1_glitch_cnt", 4'(cnt_g), 4'd1);
    chk("ch1_no_fall", 4'(cnt_f), 4'd0);

    // 7-cycle pulse rejected, 8-cycle pulse accepted on channel 2
    line[2] = 1'b1;
    repeat (7) tick();
    line[2] = 1'b0;
    cnt_g = 0; cnt_r = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      cnt_g += int'(glitch[2]);
      cnt_r += int'(rise[2]);
    end
    chk("pulse7_glitch", 4'(cnt_g), 4'd1);
    chk("pulse7_no_rise", 4'(cnt_r), 4'd0);
    line[2] = 1'b1;
    repeat (8) tick();
    line[2] = 1'b0;
    cnt_r = 0; cnt_f = 0; cnt_g = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      cnt_r += int'(rise[2]);
      cnt_f += int'(fall[2]);
      cnt_g += int'(glitch[2]);
    end
    chk("pulse8_rise", 4'(cnt_r), 4'd1);
    chk("pulse8_fall", 4'(cnt_f), 4'd1);
    chk("pulse8_no_glitch", 4'(cnt_g), 4'd0);

    // Simultaneous rise on channels 3 and 2
    line[3] = 1'b0;
    repeat (20) tick();
    line[3:2] = 2'b11;
    hit = 0; cnt_any = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (rise[3:2] == 2'b11) hit++;
      cnt_any += int'(any_change);
    end
    chk("dual_rise", 4'(hit), 4'd1);
    chk("dual_any_pulse", 4'(cnt_any), 4'd1);
`ifdef MULTI_DEBOUNCER_IRQ_EN
    chk("irq_pending32", {2'b0, event_pending[3:2]}, 4'b0011);
    chk("irq_level", {3'b0, irq}, 4'd1);
    irq_clear[2] = 1'b1;
    line[2] = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (fall[2]) begin
        tick();
        chk("irq_set_wins", {3'b0, event_pending[2]}, 4'd1);
        break;
      end
    end
    irq_clear = '0;
    line[2] = 1'b1;
    repeat (20) tick();
`endif

    // Reset while channel 0 is pending: no strobes, then a fresh full debounce
    line[0] = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    chk("rst_pend_db", {3'b0, debounced_line[0]}, 4'd0);
    chk("rst_pend_strobes", rise | fall | glitch, '0);
    reset = 1'b1;
    line[0] = 1'b1;
    hit = 0;
    for (n = 1; n <= 30; n++) begin
      tick();
      if (rise[0]) begin hit = n; break; end
    end
    chk("rst_pend_restart", 4'(hit), 4'd10);

    // Randomised traffic with lengths clustered around the debounce window
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 9) == 0) line[i] = ~line[i];
`ifdef MULTI_DEBOUNCER_IRQ_EN
      irq_clear = 4'($urandom_range(0, 15)) & {4{$urandom_range(0, 3) == 0}};
`endif
      reset = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
Parametrised N-channel debouncer for push-buttons and slow control lines feeding the ROM reader control FSM. Each channel has an input synchroniser, a per-channel counter FSM, and single-cycle rise/fall/glitch strobes. An optional sticky event/IRQ register is available. Replaces single-line debounce instances with one vector block.

Parameters:
CHANNELS, 4, number of independent input lines (>=1)
DEBOUNCE_CYCLES, 100, consecutive synchronised samples of the new level needed to accept it (>=1)
SYNC_STAGES, 2, flip-flops in each input synchroniser chain (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
line  input  CHANNELS  raw asynchronous input lines
debounced_line  output  CHANNELS  accepted stable level per channel
rise  output  CHANNELS  1-cycle pulse when debounced_line goes 0->1
fall  output  CHANNELS  1-cycle pulse when debounced_line goes 1->0
glitch  output  CHANNELS  1-cycle pulse when a pending change is abandoned
any_change  output  1  OR of rise|fall, registered alongside them

Behaviour:
- Reset (reset==0 at posedge clk), per channel i:
  - every sync stage loads line[i]; debounced_line[i] <= line[i] (no spurious edge after reset release)
  - counter <= 0; state <= STABLE; rise/fall/glitch/any_change <= 0
- Synchroniser: s[i] = last stage of a SYNC_STAGES-deep shift chain. The FSM sees only s[i].
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never wraps; it is cleared on accept or abandon.
- FSM states: STABLE, PENDING.
- STABLE:
  - s==db: stay; counter held at 0.
  - s!=db and DEBOUNCE_CYCLES==1: db<=s, pulse rise/fall, stay in STABLE.
  - s!=db otherwise: counter<=1, go to PENDING.
- PENDING:
  - s==db: abandon. counter<=0, glitch pulse, go to STABLE; db unchanged.
  - s!=db and counter==DEBOUNCE_CYCLES-1: accept. db<=s, pulse rise (s==1) or fall (s==0), counter<=0, go to STABLE.
  - s!=db otherwise: counter<=counter+1.
- Latency: a clean input step is reflected on debounced_line exactly SYNC_STAGES+DEBOUNCE_CYCLES clk edges after the first edge sampling the new level. rise/fall assert in the same cycle debounced_line changes.
- Strobes are registered and high for exactly one cycle. rise, fall and glitch are mutually exclusive per channel per cycle.
- Channels are fully independent. Simultaneous accepts on several channels all pulse in the same cycle. any_change is 1 if any bit of rise|fall is set.
- Reset mid-PENDING: the pending change is discarded and db reloads the current raw line; no strobes are issued.
- No simulation $display in synthesizable paths.

Optional Feature:
Macro MULTI_DEBOUNCER_IRQ_EN.
- Defined: adds ports irq_clear (input, CHANNELS), event_pending (output, CHANNELS) and irq (output, 1).
  - event_pending[i] sets on rise[i]|fall[i] and clears when irq_clear[i]==1.
  - If set and clear occur in the same cycle, set wins.
  - irq is the registered OR of event_pending.
  - Reset value of all three is 0.
- Not defined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package multi_debouncer_pkg: state enum (STABLE=1'b0, PENDING=1'b1) and a counter-width helper function.
- Sub-module debounce_channel: one synchroniser plus FSM plus counter with scalar ports. Instantiated CHANNELS times by generate.
- Top level holds the any_change and optional IRQ logic.

Test Plan:
All scenarios use CHANNELS=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
- Reset with line=4'b1010 -> debounced_line=4'b1010 one cycle after reset release; no rise/fall for 20 cycles.
- line[0] 0->1 held -> debounced_line[0]=1 and rise[0]=1 for 1 cycle, exactly 10 edges after the first sampling edge; any_change=1 in the same cycle.
- line[1] 1->0 for 5 cycles then back to 1 -> glitch[1] pulses once; debounced_line[1] stays 1; fall[1] never asserts.
- Pulse of exactly 7 stable cycles -> rejected (glitch); pulse of exactly 8 stable cycles -> accepted.
- line[3:2] both rise on the same edge -> rise[3:2]=2'b11 in the same cycle; any_change is a single 1-cycle pulse.
- IRQ_EN: rise[2] -> event_pending[2]=1 and irq=1 the following cycle. irq_clear[2] held during a new fall[2] -> event_pending[2] stays 1. Reset asserted while a change is PENDING -> no strobes; counter restarts from 0.
